// File: rtl/iob_vexriscv_dbus_bridge_pkg.sv
// Shared types for the VexRiscv dBus to IOb bridge: access size and FSM state encodings,
// plus the alignment rule used by the lane logic.
package iob_vexriscv_dbus_bridge_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size 3 is always illegal; halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/iob_vexriscv_dbus_bridge_lane.sv
// Combinational byte-lane logic: strobes, write-data replication and the misalignment flag
// derived from the command's size, low address bits and right-aligned data.
module iob_vexriscv_dbus_bridge_lane
  import iob_vexriscv_dbus_bridge_pkg::*;
(
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  size_e size;
  assign size = size_e'(size_i);

  assign misaligned_o = is_misaligned(size, addr_lo_i);

  always_comb begin
    wstrb_o = 4'b0000;
    if (wr_i) begin
      case (size)
        SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
        SIZE_HALF: wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        SIZE_WORD: wstrb_o = 4'b1111;
        default:   wstrb_o = 4'b0000;
      endcase
    end
  end

  // Each lane picks its source byte so the slave sees the data under whichever strobe is set.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      always_comb begin
        case (size)
          SIZE_BYTE: wdata_o[gi*LANE_W +: LANE_W] = data_i[0 +: LANE_W];
          SIZE_HALF: wdata_o[gi*LANE_W +: LANE_W] = data_i[(gi % 2)*LANE_W +: LANE_W];
          default:   wdata_o[gi*LANE_W +: LANE_W] = data_i[gi*LANE_W +: LANE_W];
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/iob_vexriscv_dbus_bridge.sv
// VexRiscv simple dBus to IOb native bus bridge with one outstanding access,
// misalignment rejection, a per-access timeout and a sticky write-error flag.
module iob_vexriscv_dbus_bridge
  import iob_vexriscv_dbus_bridge_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dbus_cmd_valid,
  output logic                dbus_cmd_ready,
  input  logic                dbus_cmd_wr,
  input  logic [1:0]          dbus_cmd_size,
  input  logic [ADDR_W-1:0]   dbus_cmd_addr,
  input  logic [DATA_W-1:0]   dbus_cmd_data,
  output logic                dbus_rsp_ready,
  output logic                dbus_rsp_error,
  output logic [DATA_W-1:0]   dbus_rsp_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err_sticky
);

  // Last count value before the 2**TIMEOUT_W-1 limit; seeing it without m_ready aborts.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e                state_q;
  logic                  cmd_ready_q;
  logic                  wr_q;
  logic                  m_valid_q;
  logic [ADDR_W-1:0]     m_address_q;
  logic [DATA_W-1:0]     m_wdata_q;
  logic [DATA_W/8-1:0]   m_wstrb_q;
  logic [TIMEOUT_W-1:0]  tmo_q;
  logic [TIMEOUT_W-1:0]  tmo_d;
  logic                  rsp_ready_q;
  logic                  rsp_error_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic                  err_sticky_q;

  logic [3:0]            lane_wstrb;
  logic [31:0]           lane_wdata;
  logic                  lane_misaligned;
  logic                  cmd_fire;

  iob_vexriscv_dbus_bridge_lane u_lane (
    .wr_i         (dbus_cmd_wr),
    .size_i       (dbus_cmd_size),
    .addr_lo_i    (dbus_cmd_addr[1:0]),
    .data_i       (dbus_cmd_data),
    .wstrb_o      (lane_wstrb),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned)
  );

  assign cmd_fire = dbus_cmd_valid && cmd_ready_q;
  assign tmo_d    = tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      wr_q         <= 1'b0;
      m_valid_q    <= 1'b0;
      m_address_q  <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      tmo_q        <= '0;
      rsp_ready_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      rsp_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            wr_q        <= dbus_cmd_wr;
            cmd_ready_q <= 1'b0;
            tmo_q       <= '0;
            if (lane_misaligned) begin
              // Rejected before reaching the bus; only reads get a response pulse.
              state_q     <= ST_RESP;
              rsp_ready_q <= !dbus_cmd_wr;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= '0;
              if (dbus_cmd_wr) err_sticky_q <= 1'b1;
            end else begin
              state_q     <= ST_BUSY;
              m_valid_q   <= 1'b1;
              m_address_q <= {dbus_cmd_addr[ADDR_W-1:2], 2'b00};
              m_wdata_q   <= lane_wdata;
              m_wstrb_q   <= lane_wstrb;
            end
          end
        end
        ST_BUSY: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (wr_q) begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              state_q     <= ST_RESP;
              rsp_ready_q <= 1'b1;
              rsp_error_q <= 1'b0;
              rsp_data_q  <= m_rdata;
            end
          end else if (tmo_q == TMO_LAST) begin
            m_valid_q   <= 1'b0;
            state_q     <= ST_RESP;
            rsp_ready_q <= !wr_q;
            rsp_error_q <= 1'b1;
            rsp_data_q  <= '0;
            if (wr_q) err_sticky_q <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_error_q <= 1'b0;
          rsp_data_q  <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          m_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dbus_cmd_ready = cmd_ready_q;
  assign dbus_rsp_ready = rsp_ready_q;
  assign dbus_rsp_error = rsp_error_q;
  assign dbus_rsp_data  = rsp_data_q;
  assign m_valid        = m_valid_q;
  assign m_address      = m_address_q;
  assign m_wdata        = m_wdata_q;
  assign m_wstrb        = m_wstrb_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_iob_vexriscv_dbus_bridge.sv
// Scoreboard bench for the dBus to IOb bridge: directed commands push expected IOb requests
// and core responses into queues; a monitor pops and compares whenever the DUT presents them.
module tb_iob_vexriscv_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbus_cmd_valid, dbus_cmd_ready, dbus_cmd_wr;
  logic [1:0]  dbus_cmd_size;
  logic [31:0] dbus_cmd_addr, dbus_cmd_data;
  logic        dbus_rsp_ready, dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        m_valid, m_ready;
  logic [31:0] m_address, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        err_sticky;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iob_vexriscv_dbus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_cmd_wr(dbus_cmd_wr), .dbus_cmd_size(dbus_cmd_size),
    .dbus_cmd_addr(dbus_cmd_addr), .dbus_cmd_data(dbus_cmd_data),
    .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_error(dbus_rsp_error),
    .dbus_rsp_data(dbus_rsp_data),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata), .err_sticky(err_sticky)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          has_wdata;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          off;
  } rsp_t;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] rd_q[$];

  int n_vec = 0;
  int n_err = 0;
  int slave_wait = 0;
  bit force_ready = 1'b0;
  int last_acc = 0;
  int last_run = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hw);
    req_t r;
    r.addr = a; r.wdata = d; r.strb = s; r.has_wdata = hw;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e, input int off);
    rsp_t s;
    s.data = d; s.err = e; s.off = off;
    exp_rsp_q.push_back(s);
  endtask

  // Monitor: samples after the slave has driven m_ready for this cycle.
  task automatic monitor();
    bit          prev_v = 1'b0;
    int          run = 0;
    req_t        r;
    rsp_t        s;
    logic [31:0] h_addr = '0, h_wdata = '0;
    logic [3:0]  h_strb = '0;
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) begin
        if (!prev_v) begin
          if (exp_req_q.size() == 0) begin
            chk("unexpected_m_valid", {32'h0, m_address}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            r = exp_req_q.pop_front();
            chk("m_address", {32'h0, m_address}, {32'h0, r.addr});
            chk("m_wstrb", {60'h0, m_wstrb}, {60'h0, r.strb});
            if (r.has_wdata) chk("m_wdata", {32'h0, m_wdata}, {32'h0, r.wdata});
          end
          h_addr = m_address; h_wdata = m_wdata; h_strb = m_wstrb;
        end else if (m_address !== h_addr || m_wdata !== h_wdata || m_wstrb !== h_strb) begin
          chk("m_hold", {m_address, m_wdata}, {h_addr, h_wdata});
        end
        run++;
      end else if (prev_v) begin
        last_run = run;
        run = 0;
      end
      prev_v = m_valid;
      if (dbus_rsp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", {32'h0, dbus_rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          s = exp_rsp_q.pop_front();
          chk("rsp_data", {32'h0, dbus_rsp_data}, {32'h0, s.data});
          chk("rsp_error", {63'h0, dbus_rsp_error}, {63'h0, s.err});
          chk("rsp_latency", 64'(cyc - last_acc), 64'(s.off));
        end
      end
    end
  endtask

  // IOb slave model: answers after slave_wait cycles of m_valid (never when negative).
  task automatic slave();
    int wcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      m_ready = 1'b0;
      m_rdata = 32'h0;
      if (force_ready) begin
        m_ready = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
      end else if (m_valid && slave_wait >= 0) begin
        if (wcnt == slave_wait) begin
          m_ready = 1'b1;
          if (m_wstrb == 4'b0000 && rd_q.size() > 0) m_rdata = rd_q.pop_front();
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!m_valid) begin
        wcnt = 0;
      end
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the handshake edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    dbus_cmd_valid = 1'b1;
    dbus_cmd_wr    = wr;
    dbus_cmd_size  = sz;
    dbus_cmd_addr  = a;
    dbus_cmd_data  = d;
    while (!dbus_cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("cmd_accept_timeout", 64'(n), 64'(0));
    last_acc = cyc;
    @(negedge clk);
    dbus_cmd_valid = 1'b0;
    dbus_cmd_data  = 32'h0;
  endtask

  task automatic wait_ready(input string name, input int exp_lat);
    int n = 0;
    while (!dbus_cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(cyc - last_acc), 64'(exp_lat));
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_rsp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("rsp_wait_timeout", 64'(exp_rsp_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    dbus_cmd_valid = 1'b0; dbus_cmd_wr = 1'b0; dbus_cmd_size = 2'd0;
    dbus_cmd_addr = 32'h0; dbus_cmd_data = 32'h0;
    m_ready = 1'b0; m_rdata = 32'h0;
    fork
      monitor();
      slave();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", {63'h0, dbus_cmd_ready}, 64'h1);
    chk("reset_m_valid", {63'h0, m_valid}, 64'h0);
    chk("reset_rsp_ready", {63'h0, dbus_rsp_ready}, 64'h0);
    chk("reset_err_sticky", {63'h0, err_sticky}, 64'h0);
    chk("reset_m_wstrb", {60'h0, m_wstrb}, 64'h0);

    // 1: word write, ready on 2nd busy cycle
    slave_wait = 1;
    push_req(32'h104, 32'hDEADBEEF, 4'b1111, 1'b1);
    issue(1'b1, 2'd2, 32'h104, 32'hDEADBEEF);
    wait_ready("wr_next_accept", 3);

    // 2: byte write at lane 3, upper data bits must not leak
    slave_wait = 0;
    push_req(32'h200, 32'hABABABAB, 4'b1000, 1'b1);
    issue(1'b1, 2'd0, 32'h203, 32'hFFFF00AB);
    wait_ready("byte_wr_accept", 2);

    // 3: half read, zero wait
    rd_q.push_back(32'h12345678);
    push_req(32'h300, 32'h0, 4'b0000, 1'b0);
    push_rsp(32'h12345678, 1'b0, 2);
    issue(1'b0, 2'd1, 32'h302, 32'h0);
    wait_ready("rd_next_accept", 3);

    // more lane patterns
    slave_wait = 2;
    push_req(32'h500, 32'hBEEFBEEF, 4'b1100, 1'b1);
    issue(1'b1, 2'd1, 32'h502, 32'h1234BEEF);
    wait_ready("half_wr_accept", 4);
    push_req(32'h600, 32'h77777777, 4'b0010, 1'b1);
    issue(1'b1, 2'd0, 32'h601, 32'h00000077);
    wait_ready("byte1_wr_accept", 4);
    rd_q.push_back(32'hCAFEF00D);
    push_req(32'h700, 32'h0, 4'b0000, 1'b0);
    push_rsp(32'hCAFEF00D, 1'b0, 4);
    issue(1'b0, 2'd2, 32'h700, 32'h0);
    wait_rsp();
    slave_wait = 0;
    @(negedge clk);
    push_req(32'h500, 32'h55555555, 4'b0011, 1'b1);
    issue(1'b1, 2'd1, 32'h500, 32'hAAAA5555);
    wait_ready("half0_wr_accept", 2);
    chk("sticky_clear_after_ok", {63'h0, err_sticky}, 64'h0);

    // 4: misaligned read, misaligned half read, then illegal-size write
    push_rsp(32'h0, 1'b1, 1);
    issue(1'b0, 2'd2, 32'h401, 32'h0);
    wait_ready("misal_rd_accept", 2);
    push_rsp(32'h0, 1'b1, 1);
    issue(1'b0, 2'd1, 32'h303, 32'h0);
    wait_ready("misal_half_accept", 2);
    chk("sticky_not_set_by_read", {63'h0, err_sticky}, 64'h0);
    issue(1'b1, 2'd3, 32'h400, 32'h11);
    wait_ready("ill_wr_accept", 2);
    chk("sticky_set_by_write", {63'h0, err_sticky}, 64'h1);

    // 5: read timeout with TIMEOUT_W=4, then a late m_ready in IDLE
    slave_wait = -1;
    push_req(32'h800, 32'h0, 4'b0000, 1'b0);
    push_rsp(32'h0, 1'b1, 16);
    issue(1'b0, 2'd2, 32'h800, 32'h0);
    wait_rsp();
    chk("timeout_valid_cycles", 64'(last_run), 64'(15));
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ready_cmd_ready", {63'h0, dbus_cmd_ready}, 64'h1);
    chk("late_ready_m_valid", {63'h0, m_valid}, 64'h0);

    // 6: reset mid-access, then back-to-back reads
    push_req(32'h900, 32'h0, 4'b0000, 1'b0);
    issue(1'b0, 2'd2, 32'h900, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_m_valid", {63'h0, m_valid}, 64'h0);
    chk("rst_mid_cmd_ready", {63'h0, dbus_cmd_ready}, 64'h1);
    chk("rst_mid_rsp_ready", {63'h0, dbus_rsp_ready}, 64'h0);
    chk("rst_mid_sticky", {63'h0, err_sticky}, 64'h0);
    slave_wait = 0;
    rd_q.push_back(32'hAAAA0001);
    push_req(32'hA00, 32'h0, 4'b0000, 1'b0);
    push_rsp(32'hAAAA0001, 1'b0, 2);
    issue(1'b0, 2'd2, 32'hA00, 32'h0);
    rd_q.push_back(32'hBBBB0002);
    push_req(32'hA04, 32'h0, 4'b0000, 1'b0);
    push_rsp(32'hBBBB0002, 1'b0, 2);
    issue(1'b0, 2'd2, 32'hA04, 32'h0);
    wait_rsp();

    repeat (5) @(negedge clk);
    chk("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
    chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
